board_ctrl: RTL

- Game sequencer and cell-state owner for the two 10x10 player boards drawn by the background/board draw stage.
- Arbitrates placement and shot requests from two player input sources and keeps each board's cell state.
- Runs the FSM CLEAR / SETUP / PLAY / GAME_OVER.
- Provides a dedicated read port that the draw pipeline polls every pixel clock.

---
 rtl/game_pkg.sv | 34 +++
 rtl/rr_arb2.sv | 37 +++
 rtl/board_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared cell/state/response types and board geometry for board_ctrl and the draw stage
package game_pkg;

  localparam int GRID_N_DEF     = 10;
  localparam int SHIP_CELLS_DEF = 17;

  localparam int CELL_PX   = 32;
  localparam int BOARD0_X0 = 96;
  localparam int BOARD0_Y0 = 192;
  localparam int BOARD1_X0 = 608;
  localparam int BOARD1_Y0 = 192;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_SHIP  = 2'd1,
    CELL_MISS  = 2'd2,
    CELL_HIT   = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    GS_CLEAR     = 2'd0,
    GS_SETUP     = 2'd1,
    GS_PLAY      = 2'd2,
    GS_GAME_OVER = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    RESP_OK      = 2'd0,
    RESP_HIT     = 2'd1,
    RESP_MISS    = 2'd2,
    RESP_INVALID = 2'd3
  } resp_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter; pointer names the favoured requester
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       clr,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
    if (clr) begin
      ptr_d = 1'b0;
    end else if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/board_ctrl.sv
// rtl/board_ctrl.sv - game sequencer and owner of both players' board cells, with a draw-side read port
module board_ctrl
  import game_pkg::*;
#(
  parameter int GRID_N     = GRID_N_DEF,
  parameter int SHIP_CELLS = SHIP_CELLS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_x,
  input  logic [7:0] req_y,
  output logic       resp_valid,
  output logic       resp_player,
  output logic [1:0] resp_code,
  input  logic       rd_board,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic [1:0] rd_cell,
  output logic [1:0] game_state,
  output logic       turn,
  output logic       winner,
  output logic [4:0] placed0,
  output logic [4:0] placed1,
  output logic [4:0] hits0,
  output logic [4:0] hits1
);

  localparam int NCELL = GRID_N * GRID_N;
  localparam int IW    = $clog2(NCELL);

  localparam logic [1:0]    ST_CLEAR     = GS_CLEAR;
  localparam logic [1:0]    ST_SETUP     = GS_SETUP;
  localparam logic [1:0]    ST_PLAY      = GS_PLAY;
  localparam logic [1:0]    ST_GAME_OVER = GS_GAME_OVER;
  localparam logic [4:0]    SHIPS        = 5'(SHIP_CELLS);
  localparam logic [IW-1:0] LAST_IDX     = IW'(NCELL - 1);

  logic [1:0]    board_q [2][NCELL];
  logic [1:0]    board_d [2][NCELL];
  logic [1:0]    state_q, state_d;
  logic          turn_q, turn_d;
  logic          winner_q, winner_d;
  logic [4:0]    placed_q [2];
  logic [4:0]    placed_d [2];
  logic [4:0]    hits_q [2];
  logic [4:0]    hits_d [2];
  logic          exec_q, exec_d;
  logic          ex_p_q, ex_p_d;
  logic [3:0]    ex_x_q, ex_x_d;
  logic [3:0]    ex_y_q, ex_y_d;
  logic [IW-1:0] clr_cnt_q, clr_cnt_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_player_q, resp_player_d;
  logic [1:0]    resp_code_q, resp_code_d;
  logic [1:0]    rd_cell_q, rd_cell_d;

  logic [1:0]    elig;
  logic [1:0]    gnt;
  logic          arb_clr;
  logic          ex_in_range;
  logic [IW-1:0] ex_idx;
  logic          ex_board;
  logic [1:0]    ex_cell;
  logic          rd_in_range;
  logic [IW-1:0] rd_idx;

  // Nobody may start a command while the previous one executes.
  always_comb begin
    elig = 2'b00;
    if (!exec_q) begin
      if (state_q == ST_SETUP) begin
        elig[0] = placed_q[0] < SHIPS;
        elig[1] = placed_q[1] < SHIPS;
      end else if (state_q == ST_PLAY) begin
        elig[turn_q] = 1'b1;
      end
    end
  end

  assign arb_clr = (state_q == ST_CLEAR) && (clr_cnt_q == LAST_IDX);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst),
    .req   (req_valid & elig),
    .clr   (arb_clr),
    .gnt   (gnt)
  );

  always_comb begin
    board_d       = board_q;
    state_d       = state_q;
    turn_d        = turn_q;
    winner_d      = winner_q;
    placed_d      = placed_q;
    hits_d        = hits_q;
    exec_d        = 1'b0;
    ex_p_d        = ex_p_q;
    ex_x_d        = ex_x_q;
    ex_y_d        = ex_y_q;
    clr_cnt_d     = clr_cnt_q;
    resp_valid_d  = 1'b0;
    resp_player_d = resp_player_q;
    resp_code_d   = resp_code_q;

    ex_in_range = (32'(ex_x_q) < GRID_N) && (32'(ex_y_q) < GRID_N);
    ex_idx      = IW'(32'(ex_y_q) * GRID_N + 32'(ex_x_q));
    // Placements land on the player's own board, shots on the opponent's.
    ex_board    = (state_q == ST_PLAY) ? ~ex_p_q : ex_p_q;
    ex_cell     = board_q[ex_board][ex_idx];

    if (|gnt) begin
      exec_d = 1'b1;
      ex_p_d = gnt[1];
      ex_x_d = gnt[1] ? req_x[7:4] : req_x[3:0];
      ex_y_d = gnt[1] ? req_y[7:4] : req_y[3:0];
    end

    if (exec_q) begin
      resp_valid_d  = 1'b1;
      resp_player_d = ex_p_q;
      resp_code_d   = RESP_INVALID;
      if (state_q == ST_SETUP) begin
        if (ex_in_range && ex_cell != CELL_SHIP) begin
          board_d[ex_board][ex_idx] = CELL_SHIP;
          placed_d[ex_p_q]          = placed_q[ex_p_q] + 5'd1;
          resp_code_d               = RESP_OK;
          if (placed_d[0] == SHIPS && placed_d[1] == SHIPS) begin
            state_d = ST_PLAY;
            turn_d  = 1'b0;
          end
        end
      end else if (state_q == ST_PLAY && ex_in_range) begin
        if (ex_cell == CELL_SHIP) begin
          board_d[ex_board][ex_idx] = CELL_HIT;
          hits_d[ex_p_q]            = hits_q[ex_p_q] + 5'd1;
          resp_code_d               = RESP_HIT;
          if (hits_d[ex_p_q] == SHIPS) begin
            state_d  = ST_GAME_OVER;
            winner_d = ex_p_q;
          end else begin
            turn_d = ~turn_q;
          end
        end else if (ex_cell == CELL_EMPTY) begin
          board_d[ex_board][ex_idx] = CELL_MISS;
          resp_code_d               = RESP_MISS;
          turn_d                    = ~turn_q;
        end
      end
    end

    case (state_q)
      ST_GAME_OVER: begin
        if (|req_valid) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        board_d[0][clr_cnt_q] = CELL_EMPTY;
        board_d[1][clr_cnt_q] = CELL_EMPTY;
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = ST_SETUP;
          clr_cnt_d = '0;
          turn_d    = 1'b0;
          winner_d  = 1'b0;
          placed_d  = '{default: 5'd0};
          hits_d    = '{default: 5'd0};
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rd_in_range = (32'(rd_x) < GRID_N) && (32'(rd_y) < GRID_N);
  assign rd_idx      = IW'(32'(rd_y) * GRID_N + 32'(rd_x));
  assign rd_cell_d   = rd_in_range ? board_q[rd_board][rd_idx] : CELL_EMPTY;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NCELL; i++) begin
          board_q[b][i] <= CELL_EMPTY;
        end
        placed_q[b] <= 5'd0;
        hits_q[b]   <= 5'd0;
      end
      state_q       <= ST_SETUP;
      turn_q        <= 1'b0;
      winner_q      <= 1'b0;
      exec_q        <= 1'b0;
      ex_p_q        <= 1'b0;
      ex_x_q        <= 4'd0;
      ex_y_q        <= 4'd0;
      clr_cnt_q     <= '0;
      resp_valid_q  <= 1'b0;
      resp_player_q <= 1'b0;
      resp_code_q   <= RESP_OK;
      rd_cell_q     <= CELL_EMPTY;
    end else begin
      board_q       <= board_d;
      placed_q      <= placed_d;
      hits_q        <= hits_d;
      state_q       <= state_d;
      turn_q        <= turn_d;
      winner_q      <= winner_d;
      exec_q        <= exec_d;
      ex_p_q        <= ex_p_d;
      ex_x_q        <= ex_x_d;
      ex_y_q        <= ex_y_d;
      clr_cnt_q     <= clr_cnt_d;
      resp_valid_q  <= resp_valid_d;
      resp_player_q <= resp_player_d;
      resp_code_q   <= resp_code_d;
      rd_cell_q     <= rd_cell_d;
    end
  end

  assign req_ready   = gnt;
  assign resp_valid  = resp_valid_q;
  assign resp_player = resp_player_q;
  assign resp_code   = resp_code_q;
  assign rd_cell     = rd_cell_q;
  assign game_state  = state_q;
  assign turn        = turn_q;
  assign winner      = winner_q;
  assign placed0     = placed_q[0];
  assign placed1     = placed_q[1];
  assign hits0       = hits_q[0];
  assign hits1       = hits_q[1];

endmodule
